// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor / BTB.
// Holds control opcodes, pc_sel encodings, the BTB entry layout and
// opcode classification helpers.
// Entry fields are sized for the largest supported configuration
// (PCW <= 32, CTR_W <= 8); narrower builds zero-extend into them.
package bp_pkg;

  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BLT = 4'b1001;
  localparam logic [3:0] OP_BLE = 4'b1010;
  localparam logic [3:0] OP_JAL = 4'b1100;
  localparam logic [3:0] OP_JLR = 4'b1101;
  localparam logic [3:0] OP_JRI = 4'b1111;

  localparam logic [1:0] PCSEL_SEQ   = 2'b00;
  localparam logic [1:0] PCSEL_PRED  = 2'b01;
  localparam logic [1:0] PCSEL_REDIR = 2'b10;

  localparam int unsigned BP_PCW_MAX   = 32;
  localparam int unsigned BP_CTR_W_MAX = 8;

  typedef struct packed {
    logic                    valid;
    logic [BP_PCW_MAX-1:0]   tag;
    logic [BP_PCW_MAX-1:0]   target;
    logic [BP_CTR_W_MAX-1:0] ctr;
  } btb_entry_t;

  // Conditional branches: direction comes from EX
  function automatic logic is_cond_op(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BLE);
  endfunction

  // Jumps: always taken
  function automatic logic is_uncond_op(input logic [3:0] op);
    return (op == OP_JAL) || (op == OP_JLR) || (op == OP_JRI);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter next-value logic.
// Ports: ctr (current value), up (1 = increment, 0 = decrement),
//        ctr_next_c (combinational next value, clamped at 0 and all-ones).
module bp_sat_ctr #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             up,
  output logic [CTR_W-1:0] ctr_next_c
);

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  always_comb begin
    ctr_next_c = ctr;
    if (up) begin
      if (ctr != CTR_MAX) ctr_next_c = ctr + CTR_W'(1);
    end else begin
      if (ctr != '0) ctr_next_c = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. IF gets a combinational taken/target prediction for fetch_pc;
// control instructions resolved in EX train the table and raise flush only
// on a misprediction.
// Ports: clk, rst (async active-high); fetch_pc -> pred_taken/pred_target;
//        ex_* resolve port -> flush, pc_sel, redirect_pc.
// Optional macro BP_STATS_EN adds stat_branches / stat_mispredicts
// (16-bit saturating event counters).
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned PCW     = 16,
  parameter int unsigned IW      = 16,
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned CTR_W   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PCW-1:0] fetch_pc,
  output logic           pred_taken,
  output logic [PCW-1:0] pred_target,
  input  logic           ex_valid,
  input  logic [IW-1:0]  ex_ir,
  input  logic [PCW-1:0] ex_pc,
  input  logic           ex_taken,
  input  logic [PCW-1:0] ex_target,
  input  logic           ex_pred_taken,
  input  logic [PCW-1:0] ex_pred_target,
  output logic           flush,
  output logic [1:0]     pc_sel,
  output logic [PCW-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [15:0]    stat_branches,
  output logic [15:0]    stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  btb_entry_t       btb_q [ENTRIES];
  logic [CTR_W-1:0] ctr_next [ENTRIES];

  logic [3:0]       opcode;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] e_idx;
  logic             f_hit;
  logic             e_hit;
  logic             resolve;
  logic             actual_taken;
  logic             mispredict;
  logic             unused_ir_bits;

  assign opcode         = ex_ir[IW-1:IW-4];
  assign unused_ir_bits = ^ex_ir[IW-5:0];

  // Fetch-side lookup from registered table state
  assign f_idx = fetch_pc[IDX_W-1:0];
  assign f_hit = btb_q[f_idx].valid &&
                 (btb_q[f_idx].tag == BP_PCW_MAX'(fetch_pc[PCW-1:IDX_W]));

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (f_hit) begin
      pred_taken  = btb_q[f_idx].ctr[CTR_W-1];
      pred_target = btb_q[f_idx].target[PCW-1:0];
    end
  end

  // Resolve-side classification and misprediction detection
  assign e_idx        = ex_pc[IDX_W-1:0];
  assign e_hit        = btb_q[e_idx].valid &&
                        (btb_q[e_idx].tag == BP_PCW_MAX'(ex_pc[PCW-1:IDX_W]));
  assign resolve      = ex_valid && (is_cond_op(opcode) || is_uncond_op(opcode));
  assign actual_taken = is_uncond_op(opcode) || ex_taken;

  always_comb begin
    mispredict = 1'b0;
    if (resolve) begin
      mispredict = (actual_taken != ex_pred_taken) ||
                   (actual_taken && (ex_target != ex_pred_target));
    end
  end

  // PC-update mux select; a redirect overrides the fetch prediction
  always_comb begin
    flush       = mispredict;
    redirect_pc = '0;
    pc_sel      = pred_taken ? PCSEL_PRED : PCSEL_SEQ;
    if (mispredict) begin
      pc_sel      = PCSEL_REDIR;
      redirect_pc = actual_taken ? ex_target : ex_pc + PCW'(1);
    end
  end

  // One counter-update instance per entry
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
      .ctr        (btb_q[i].ctr[CTR_W-1:0]),
      .up         (actual_taken),
      .ctr_next_c (ctr_next[i])
    );
  end

  // Table training: update on hit, allocate weakly-taken on taken miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_W_MAX'(1)};
      end
    end else if (resolve) begin
      if (e_hit) begin
        btb_q[e_idx].ctr <= BP_CTR_W_MAX'(ctr_next[e_idx]);
        if (actual_taken) btb_q[e_idx].target <= BP_PCW_MAX'(ex_target);
      end else if (actual_taken) begin
        btb_q[e_idx] <= '{valid:  1'b1,
                          tag:    BP_PCW_MAX'(ex_pc[PCW-1:IDX_W]),
                          target: BP_PCW_MAX'(ex_target),
                          ctr:    BP_CTR_W_MAX'(1) << (CTR_W - 1)};
      end
    end
  end

`ifdef BP_STATS_EN
  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve && (stat_branches != 16'hFFFF))
        stat_branches <= stat_branches + 16'd1;
      if (mispredict && (stat_mispredicts != 16'hFFFF))
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: a directed vector table,
// a mid-run asynchronous reset sequence, randomized traffic against a
// behavioural BTB model and, with BP_STATS_EN, the statistics counters.
module tb_branch_predictor_btb;
  import bp_pkg::*;

  localparam int ENTRIES = 8;
  localparam int CTR_W   = 2;
  localparam int CTR_MAX = (1 << CTR_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        ex_valid;
  logic [15:0] ex_ir;
  logic [15:0] ex_pc;
  logic        ex_taken;
  logic [15:0] ex_target;
  logic        ex_pred_taken;
  logic [15:0] ex_pred_target;
  logic        flush;
  logic [1:0]  pc_sel;
  logic [15:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor_btb #(.PCW(16), .IW(16), .ENTRIES(ENTRIES), .CTR_W(CTR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_ir          (ex_ir),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .pc_sel         (pc_sel),
    .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] fpc;
    logic        ev;
    logic [3:0]  op;
    logic [15:0] epc;
    logic        et;
    logic [15:0] etg;
    logic        ept;
    logic [15:0] eptg;
    logic        xpt;
    logic [15:0] xptg;
    logic        xfl;
    logic [1:0]  xsel;
    logic [15:0] xred;
  } vec_t;

  function automatic vec_t mk(logic [15:0] fpc, logic ev, logic [3:0] op, logic [15:0] epc,
                              logic et, logic [15:0] etg, logic ept, logic [15:0] eptg,
                              logic xpt, logic [15:0] xptg, logic xfl, logic [1:0] xsel,
                              logic [15:0] xred);
    vec_t v;
    v.fpc = fpc; v.ev = ev; v.op = op; v.epc = epc; v.et = et; v.etg = etg;
    v.ept = ept; v.eptg = eptg; v.xpt = xpt; v.xptg = xptg; v.xfl = xfl;
    v.xsel = xsel; v.xred = xred;
    return v;
  endfunction

  task automatic drive(input logic [15:0] fpc, input logic ev, input logic [3:0] op,
                       input logic [15:0] epc, input logic et, input logic [15:0] etg,
                       input logic ept, input logic [15:0] eptg);
    fetch_pc = fpc; ex_valid = ev; ex_ir = {op, 12'h000}; ex_pc = epc;
    ex_taken = et; ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg;
  endtask

  task automatic idle(input logic [15:0] fpc);
    drive(fpc, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  // Behavioural reference: index = pc mod ENTRIES, tag = pc div ENTRIES
  int m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_ctr   [ENTRIES];

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
  endfunction

  function automatic int m_hit(input int pc);
    return m_valid[pc % ENTRIES] != 0 && m_tag[pc % ENTRIES] == pc / ENTRIES;
  endfunction

  function automatic int m_taken(input int pc);
    return m_hit(pc) != 0 && m_ctr[pc % ENTRIES] >= (1 << (CTR_W - 1));
  endfunction

  function automatic int m_target(input int pc);
    return (m_hit(pc) != 0) ? m_tgt[pc % ENTRIES] : 0;
  endfunction

  function automatic void m_train(input int pc, input int taken, input int tgt);
    int i;
    i = pc % ENTRIES;
    if (m_hit(pc) != 0) begin
      if (taken != 0) begin
        m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (taken != 0) begin
      m_valid[i] = 1; m_tag[i] = pc / ENTRIES; m_tgt[i] = tgt;
      m_ctr[i] = 1 << (CTR_W - 1);
    end
  endfunction

  function automatic logic [3:0] pick_op(input int k);
    case (k)
      0: return OP_BEQ;
      1: return OP_BLT;
      2: return OP_BLE;
      3: return OP_JAL;
      4: return OP_JLR;
      5: return OP_JRI;
      6: return 4'b0000;
      default: return 4'b0111;
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    idle(16'h0010);
    m_reset();

    vecs.push_back(mk(16'h0010, 0, 4'h0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0000));
    vecs.push_back(mk(16'h0010, 1, OP_JAL, 16'h0010, 0, 16'h0040, 0, 16'h0000, 0, 16'h0000, 1, 2'b10, 16'h0040));
    vecs.push_back(mk(16'h0010, 0, 4'h0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 2'b01, 16'h0000));
    vecs.push_back(mk(16'h0020, 1, OP_BEQ, 16'h0020, 1, 16'h0030, 0, 16'h0000, 0, 16'h0000, 1, 2'b10, 16'h0030));
    vecs.push_back(mk(16'h0020, 1, OP_BEQ, 16'h0020, 1, 16'h0030, 1, 16'h0030, 1, 16'h0030, 0, 2'b01, 16'h0000));
    vecs.push_back(mk(16'h0020, 1, OP_BEQ, 16'h0020, 1, 16'h0030, 1, 16'h0030, 1, 16'h0030, 0, 2'b01, 16'h0000));
    vecs.push_back(mk(16'h0020, 1, OP_BEQ, 16'h0020, 0, 16'h0030, 1, 16'h0030, 1, 16'h0030, 1, 2'b10, 16'h0021));
    vecs.push_back(mk(16'h0020, 1, OP_BEQ, 16'h0020, 0, 16'h0030, 1, 16'h0030, 1, 16'h0030, 1, 2'b10, 16'h0021));
    vecs.push_back(mk(16'h0020, 0, 4'h0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0030, 0, 2'b00, 16'h0000));
    vecs.push_back(mk(16'h0003, 1, OP_JAL, 16'h0003, 0, 16'h0050, 0, 16'h0000, 0, 16'h0000, 1, 2'b10, 16'h0050));
    vecs.push_back(mk(16'h0003, 1, OP_JAL, 16'h000B, 0, 16'h0060, 0, 16'h0000, 1, 16'h0050, 1, 2'b10, 16'h0060));
    vecs.push_back(mk(16'h0003, 0, 4'h0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0000));
    vecs.push_back(mk(16'h0005, 1, OP_JLR, 16'h0005, 0, 16'h0100, 0, 16'h0000, 0, 16'h0000, 1, 2'b10, 16'h0100));
    vecs.push_back(mk(16'h0005, 1, OP_JLR, 16'h0005, 0, 16'h0200, 1, 16'h0100, 1, 16'h0100, 1, 2'b10, 16'h0200));
    vecs.push_back(mk(16'h0005, 0, 4'h0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 0, 2'b01, 16'h0000));
    vecs.push_back(mk(16'h0001, 1, OP_BEQ, 16'h0020, 1, 16'h0030, 1, 16'h0030, 0, 16'h0000, 0, 2'b00, 16'h0000));
    vecs.push_back(mk(16'h0020, 0, OP_BEQ, 16'h0020, 0, 16'h0030, 1, 16'h0030, 1, 16'h0030, 0, 2'b01, 16'h0000));
    vecs.push_back(mk(16'h0020, 0, 4'h0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0030, 0, 2'b01, 16'h0000));
    vecs.push_back(mk(16'h0020, 1, 4'h0,   16'h0020, 1, 16'h0099, 0, 16'h0000, 1, 16'h0030, 0, 2'b01, 16'h0000));
    vecs.push_back(mk(16'h0020, 0, 4'h0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0030, 0, 2'b01, 16'h0000));
    vecs.push_back(mk(16'h0007, 1, OP_BLE, 16'h0007, 0, 16'h0070, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0000));
    vecs.push_back(mk(16'hFFFF, 1, OP_BLT, 16'hFFFF, 0, 16'h1234, 1, 16'h1234, 0, 16'h0000, 1, 2'b10, 16'h0000));
    vecs.push_back(mk(16'hFFFF, 0, 4'h0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0000));
    vecs.push_back(mk(16'h0006, 1, OP_JRI, 16'h0006, 0, 16'h0077, 1, 16'h0077, 0, 16'h0000, 0, 2'b00, 16'h0000));
    vecs.push_back(mk(16'h0006, 0, 4'h0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0077, 0, 2'b01, 16'h0000));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_pred_taken", 32'(pred_taken), 32'd0);
    chk("reset_pred_target", 32'(pred_target), 32'd0);
    rst = 1'b0;

    // Directed vector table, one vector per cycle
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].fpc, vecs[k].ev, vecs[k].op, vecs[k].epc, vecs[k].et, vecs[k].etg,
            vecs[k].ept, vecs[k].eptg);
      #1;
      chk($sformatf("v%0d_pred_taken", k), 32'(pred_taken), 32'(vecs[k].xpt));
      chk($sformatf("v%0d_pred_target", k), 32'(pred_target), 32'(vecs[k].xptg));
      chk($sformatf("v%0d_flush", k), 32'(flush), 32'(vecs[k].xfl));
      chk($sformatf("v%0d_pc_sel", k), 32'(pc_sel), 32'(vecs[k].xsel));
      if (vecs[k].xfl) chk($sformatf("v%0d_redirect", k), 32'(redirect_pc), 32'(vecs[k].xred));
    end

    // Asynchronous reset mid-cycle while a taken JAL is pending
    @(negedge clk);
    drive(16'h0006, 1'b1, OP_JAL, 16'h0008, 1'b0, 16'h0099, 1'b0, 16'h0000);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pred_taken", 32'(pred_taken), 32'd0);
    chk("midrst_pred_target", 32'(pred_target), 32'd0);
    chk("midrst_flush_comb", 32'(flush), 32'd1);
    @(negedge clk);
    idle(16'h0006);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] pcs [4];
      pcs = '{16'h0006, 16'h0005, 16'h0020, 16'h0008};
      fetch_pc = pcs[k];
      #1;
      chk($sformatf("postrst_miss_%h", pcs[k]), 32'({pred_taken, pred_target}), 32'd0);
    end

    // Randomized traffic against the behavioural model
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      int fpc, epc, op_k, ev, et, etg, ept, eptg, ctl, unc, act, misp;
      @(negedge clk);
      fpc  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 31));
      epc  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 31));
      op_k = $urandom_range(0, 7);
      ev   = ($urandom_range(0, 9) != 0);
      et   = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: etg = 16'h0100;
        1: etg = 16'h0200;
        2: etg = 16'hFFFF;
        default: etg = $urandom_range(0, 65535);
      endcase
      if ($urandom_range(0, 3) != 0) begin
        ept = m_taken(epc); eptg = m_target(epc);
      end else begin
        ept = $urandom_range(0, 1); eptg = $urandom_range(0, 65535);
      end
      drive(16'(fpc), 1'(ev), pick_op(op_k), 16'(epc), 1'(et), 16'(etg), 1'(ept), 16'(eptg));
      unc  = (op_k >= 3 && op_k <= 5);
      ctl  = (ev != 0) && (op_k <= 5);
      act  = (unc != 0) || (et != 0);
      misp = (ctl != 0) && ((act != ept) || (act != 0 && etg != eptg));
      #1;
      chk("rnd_pred_taken", 32'(pred_taken), 32'(m_taken(fpc)));
      chk("rnd_pred_target", 32'(pred_target), 32'(m_target(fpc)));
      chk("rnd_flush", 32'(flush), 32'(misp));
      chk("rnd_pc_sel", 32'(pc_sel),
          (misp != 0) ? 32'd2 : ((m_taken(fpc) != 0) ? 32'd1 : 32'd0));
      if (misp != 0)
        chk("rnd_redirect", 32'(redirect_pc), (act != 0) ? 32'(etg) : 32'((epc + 1) % 65536));
      if (ctl != 0) m_train(epc, act, etg);
    end

`ifdef BP_STATS_EN
    // Statistics: 5 resolved branches, 2 of them mispredicted
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("stat_branches_reset", 32'(stat_branches), 32'd0);
    chk("stat_mispredicts_reset", 32'(stat_mispredicts), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(16'h0, 1'b1, OP_JAL, 16'h0010, 1'b0, 16'h0040, 1'b0, 16'h0000);
    @(negedge clk);
    drive(16'h0, 1'b1, OP_JAL, 16'h0010, 1'b0, 16'h0040, 1'b1, 16'h0040);
    @(negedge clk);
    drive(16'h0, 1'b1, OP_BEQ, 16'h0021, 1'b0, 16'h0050, 1'b0, 16'h0000);
    @(negedge clk);
    drive(16'h0, 1'b0, OP_BEQ, 16'h0021, 1'b1, 16'h0050, 1'b0, 16'h0000);
    @(negedge clk);
    drive(16'h0, 1'b1, OP_BEQ, 16'h0022, 1'b0, 16'h0050, 1'b1, 16'h0050);
    @(negedge clk);
    drive(16'h0, 1'b1, 4'b0011, 16'h0023, 1'b1, 16'h0050, 1'b0, 16'h0000);
    @(negedge clk);
    drive(16'h0, 1'b1, OP_JRI, 16'h0024, 1'b0, 16'h0060, 1'b1, 16'h0060);
    @(negedge clk);
    idle(16'h0);
    #1;
    chk("stat_branches_5", 32'(stat_branches), 32'd5);
    chk("stat_mispredicts_2", 32'(stat_mispredicts), 32'd2);
    drive(16'h0, 1'b1, OP_JAL, 16'h0010, 1'b0, 16'h0040, 1'b0, 16'h0000);
    repeat (65540) @(negedge clk);
    idle(16'h0);
    #1;
    chk("stat_branches_sat", 32'(stat_branches), 32'h0000FFFF);
    chk("stat_mispredicts_sat", 32'(stat_mispredicts), 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised successor to the EX-stage branch handler: a direct-mapped branch target buffer with per-entry saturating direction counters. The fetch stage gets a taken/target prediction every cycle. Control instructions resolved in EX train the table, and the pipeline is flushed only on a misprediction rather than on every control instruction. It sits between IF (lookup port) and EX (resolve port) and drives the PC-update mux select.

## Interface
- PCW, 16: PC and target width
- IW, 16: instruction width; opcode is IR[IW-1:IW-4]
- ENTRIES, 8: BTB entries; power of two, ≥2
- CTR_W, 2: direction counter width, ≥1
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_pc  in  PCW  PC being fetched
- pred_taken  out  1  BTB hit and counter MSB set
- pred_target  out  PCW  stored target on hit, else 0
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_ir  in  IW  EX-stage instruction
- ex_pc  in  PCW  EX-stage instruction PC
- ex_taken  in  1  actual direction; ignored for unconditional opcodes
- ex_target  in  PCW  actual target computed in EX
- ex_pred_taken  in  1  prediction made for this instruction, carried from IF
- ex_pred_target  in  PCW  predicted target, carried from IF
- flush  out  1  kill IF/ID/RR younger instructions this cycle
- pc_sel  out  2  00 = PC+1, 01 = pred_target, 10 = redirect_pc
- redirect_pc  out  PCW  correct next PC on misprediction
- stat_branches, stat_mispredicts  out  16 each  present only with BP_STATS_EN

## Operation
- Index = PC[log2(ENTRIES)-1:0]. Tag = the remaining upper PC bits. Each entry holds valid, tag, target and a CTR_W-bit counter.
- Lookup is combinational from registered state. A hit requires valid and tag match.
- Control opcodes and their actual direction:
  - Conditional 1000/1001/1010: direction is ex_taken.
  - 1100 (JAL), 1101 (JLR), 1111 (JRI): always taken.
  - All other opcodes, or ex_valid = 0: no resolve action.
- Mispredict when a control instruction resolves and either:
  - actual direction ≠ ex_pred_taken, or
  - actual direction is taken and ex_target ≠ ex_pred_target.
- On mispredict:
  - flush = 1 and pc_sel = 10.
  - redirect_pc = ex_target if taken, else ex_pc+1 (mod 2^PCW).
- Otherwise, for the pc_sel output:
  - flush = 0.
  - pc_sel = 01 if pred_taken, else 00.
  - A mispredict redirect overrides the fetch-side prediction in the same cycle.
- Training, on any resolved control instruction at ex_pc:
  - Hit: counter +1 saturating at all-ones if taken, −1 saturating at 0 if not taken. Target is rewritten with ex_target when taken.
  - Miss and taken: allocate the entry, overwriting whatever occupies the index. Set valid and tag, set target to ex_target, set counter to 10…0 (weakly taken).
  - Miss and not taken: no change.

## Timing
- Prediction: 0-cycle combinational from fetch_pc.
- flush, pc_sel and redirect_pc: combinational, in the same cycle as the resolving instruction in EX.
- Table write takes effect at the next rising edge.
- A lookup and update to the same index in the same cycle returns the pre-update entry.
- Reset (asynchronous, any time, including mid-update):
  - all valid bits cleared and counters set to 0…01;
  - pred_taken = 0 and pred_target = 0;
  - stat counters = 0.
- Combinational outputs follow their inputs during reset.
- After reset deasserts, the first edge may already train the table.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on each resolved control instruction.
  - stat_mispredicts increments on each flush.
  - Both are 16-bit, saturate at 0xFFFF and are cleared by rst.
- BP_STATS_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package bp_pkg holds:
  - opcode constants OP_BEQ = 1000, OP_BLT = 1001, OP_BLE = 1010, OP_JAL = 1100, OP_JLR = 1101, OP_JRI = 1111;
  - pc_sel encodings PCSEL_SEQ, PCSEL_PRED, PCSEL_REDIR;
  - the BTB entry struct typedef.
- One sub-module, bp_sat_ctr: a CTR_W-bit saturating up/down counter update function, used per entry.

## Test plan
- Reset, then fetch_pc = 0x0010 → pred_taken = 0, pred_target = 0. Resolve OP_JAL at 0x0010, target 0x0040, pred_taken = 0 → flush = 1, pc_sel = 10, redirect_pc = 0x0040. Next cycle fetch_pc = 0x0010 → hit, pred_taken = 1, target 0x0040.
- BEQ at 0x0020, resolved taken 3×, then not taken (counter 11→10) → still pred_taken = 1. A second not-taken (→01) → pred_taken = 0. The mispredicted not-taken gives redirect_pc = 0x0021.
- Aliasing with ENTRIES = 8: taken branch at 0x0003 allocated, then taken branch at 0x000B allocated → lookup of 0x0003 misses.
- JLR with correct direction but wrong target (pred 0x0100, actual 0x0200) → flush = 1, redirect_pc = 0x0200, entry target updated to 0x0200.
- Correctly predicted taken BEQ → flush = 0. ex_valid = 0 with a branch opcode → no flush, no table change. rst pulsed mid-run → all lookups miss.
- BP_STATS_EN: 5 resolved branches with 2 mispredicts → stat_branches = 5, stat_mispredicts = 2. Force 0xFFFF + 1 events → counters hold at 0xFFFF.
